dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single-port, synchronous-read data memory (1024 x 32) between the processor load/store path (core port) and a debug/loader port.
- The debug port preloads arrays (e.g. words 100..109 before a sort run) and dumps them afterwards.
- Core has fixed priority; a starvation counter guarantees debug progress.
- Sits between the datapath memory stage and the dmem instance.

Parameters:
- ADDR_W, 10, word address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive denied debug cycles after which debug is forced to win one cycle (1..15).
- CNT_W, 16, width of conflict statistics counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request, held until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core word address.
- core_wdata  in  DATA_W  core write data.
- core_gnt  out  1  combinational grant, access performed this cycle.
- core_rvalid  out  1  read data valid, one cycle after a granted read.
- core_rdata  out  DATA_W  read data to core.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request, same rules as core.
- dbg_gnt  out  1  debug grant.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_W  read data to debug.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we = 0.
- conflict_cnt  out  CNT_W  cycles in which both ports requested.

Behaviour:
- Reset (reset = 0, asynchronous): wait_cnt = 0, rd_owner = none, core_rvalid = dbg_rvalid = 0, conflict_cnt = 0.
  - While reset is asserted: all grants 0, mem_en = 0, mem_we = 0.
  - Data outputs are 0 during reset.
- Grant (combinational, same cycle):
  - Only core requests: core wins.
  - Only debug requests: debug wins.
  - Both request: core wins unless wait_cnt == MAX_WAIT, in which case debug wins.
  - At most one grant is high per cycle.
- Memory drive when a grant is high:
  - mem_en = 1; mem_we/mem_addr/mem_wdata come from the granted port.
  - With no grant: mem_en = 0, mem_we = 0.
- wait_cnt:
  - Increments each cycle with dbg_req = 1 and dbg_gnt = 0, saturating at MAX_WAIT.
  - Clears to 0 on any cycle with dbg_gnt = 1 or dbg_req = 0.
- Read return:
  - A granted read (we = 0) registers rd_owner for the next cycle.
  - Next cycle: the owner's rvalid = 1 and its rdata = mem_rdata; the other port's rvalid = 0.
  - Writes never produce rvalid.
  - Latency is exactly 1 cycle, including back-to-back reads and alternating owners.
- rdata holds its last returned value when rvalid = 0 (registered capture enable = rvalid).
- conflict_cnt increments when core_req and dbg_req are both 1; it saturates at all-ones.
- A requester that drops req without a grant is legal; no state is kept except wait_cnt clearing.
- Reset asserted mid-read: the pending rvalid is discarded and no rvalid follows deassertion.
- The arbiter imposes no hazard ordering between ports. Same-address write/read conflicts across ports are resolved by grant order only.

Test Plan:
- Reset: assert reset = 0 with both reqs high → all grants 0, mem_en = 0, conflict_cnt = 0. Release → core_gnt = 1 in the first cycle.
- Debug preload: dbg writes 10,9,...,1 to addr 100..109 with core idle → 10 consecutive dbg_gnt. Readback of 100 returns dbg_rvalid = 1 with rdata = 10 one cycle later; core_rvalid stays 0.
- Priority and starvation: both req continuously with MAX_WAIT = 4 → grant pattern C,C,C,C,D repeating. conflict_cnt = 10 after 10 cycles.
- Back-to-back mixed reads: core read 101, dbg read 102 in the forced cycle, core read 103 → each rvalid on its own port exactly 1 cycle later with the correct word, never both.
- Write then read, same address: core writes 0xDEADBEEF to 105, dbg reads 105 next cycle → dbg_rdata = 0xDEADBEEF.
- Mid-read reset: core read granted, reset pulsed low for 1 cycle before the return edge → core_rvalid never asserts. Counters are 0 after release.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous-read data memory between the core load/store path and a
// debug/loader port: core has fixed priority, a starvation counter forces debug through.
module dmem_port_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  conflict_cnt
);

   typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} owner_t;

   owner_t            rd_owner;
   logic [3:0]        wait_cnt;
   logic [DATA_W-1:0] core_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic              force_dbg;

   // Debug wins a conflict only once it has been denied MAX_WAIT cycles in a row;
   // reset (low) suppresses every grant so nothing reaches the memory.
   always_comb begin
      force_dbg = (wait_cnt == 4'(MAX_WAIT));
      core_gnt  = reset && core_req && !(dbg_req && force_dbg);
      dbg_gnt   = reset && dbg_req && !(core_req && !force_dbg);
      mem_en    = core_gnt || dbg_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (core_gnt) begin
         mem_we    = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end else if (dbg_gnt) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   // Read data passes straight from the memory in the return cycle and is held after.
   always_comb begin
      core_rvalid = (rd_owner == OWN_CORE);
      dbg_rvalid  = (rd_owner == OWN_DBG);
      core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
      dbg_rdata   = dbg_rvalid  ? mem_rdata : dbg_rdata_q;
   end

   // Starvation counter, read-return owner, held read data and conflict statistics.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt     <= '0;
         rd_owner     <= OWN_NONE;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
         conflict_cnt <= '0;
      end else begin
         if (!dbg_req || dbg_gnt)
            wait_cnt <= '0;
         else if (wait_cnt != 4'(MAX_WAIT))
            wait_cnt <= wait_cnt + 4'd1;

         if (core_gnt && !core_we)
            rd_owner <= OWN_CORE;
         else if (dbg_gnt && !dbg_we)
            rd_owner <= OWN_DBG;
         else
            rd_owner <= OWN_NONE;

         if (core_rvalid)
            core_rdata_q <= mem_rdata;
         if (dbg_rvalid)
            dbg_rdata_q <= mem_rdata;

         if (core_req && dbg_req && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule
